// File: rtl/sha3_miner_pkg.sv
// sha3_miner_pkg: shared control/status bit positions and sequencer state encoding.
package sha3_miner_pkg;
    localparam int CTL_RUN           = 0;
    localparam int CTL_TEST          = 1;
    localparam int CTL_PAD_LAST_LSB  = 2;
    localparam int CTL_PAD_FIRST_LSB = 10;
    localparam int STAT_FOUND        = 0;
    localparam int STAT_RUNNING      = 1;
    localparam int STAT_TESTING      = 2;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;
endpackage

// File: rtl/sha3_target_cmp.sv
// sha3_target_cmp: 256-bit unsigned digest < target with an optional output register.
module sha3_target_cmp #(
    parameter int TAG_W   = 64,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [255:0]     digest_i,
    input  logic [255:0]     target_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic             lt_o,
    output logic [TAG_W-1:0] tag_o
);
    logic             lt_c;
    logic             valid_q;
    logic             lt_q;
    logic [TAG_W-1:0] tag_q;
    assign lt_c = digest_i < target_i;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            lt_q    <= 1'b0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_i;
            lt_q    <= lt_c;
            tag_q   <= tag_i;
        end
    end
    assign valid_o = REG_OUT ? valid_q : valid_i;
    assign lt_o    = REG_OUT ? lt_q : lt_c;
    assign tag_o   = REG_OUT ? tag_q : tag_i;
endmodule

// File: rtl/sha3_nonce_ctrl.sv
// sha3_nonce_ctrl: issues tagged nonces to the SHA3 engine, latches the first digest below difficulty.
module sha3_nonce_ctrl
    import sha3_miner_pkg::*;
#(
    parameter int PIPE_DEPTH = 24,
    parameter int NONCE_W    = 64,
    parameter bit CMP_REG    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [255:0]       header,
    input  logic [255:0]       difficulty,
    input  logic [NONCE_W-1:0] start_nonce,
    input  logic [17:0]        control,
    output logic               hash_in_valid,
    input  logic               hash_in_ready,
    output logic [NONCE_W-1:0] hash_in_nonce,
    output logic [255:0]       hash_header,
    output logic [7:0]         hash_pad_first,
    output logic [7:0]         hash_pad_last,
    input  logic               hash_out_valid,
    input  logic [255:0]       hash_out_digest,
    input  logic [NONCE_W-1:0] hash_out_nonce,
    output logic [NONCE_W-1:0] solution,
    output logic [2:0]         status,
    output logic               irq
);
    localparam int            IW    = $clog2(PIPE_DEPTH + 1);
    localparam logic [IW-1:0] DEPTH = IW'(PIPE_DEPTH);

    state_e             state_q, state_d;
    logic [NONCE_W-1:0] cnt_q, cnt_d;
    logic [IW-1:0]      infl_q, infl_d;
    logic               valid_q, valid_d;
    logic [NONCE_W-1:0] sol_q, sol_d;
    logic               found_q, found_d;
    logic               testing_q, testing_d;
    logic [255:0]       hdr_q, hdr_d;
    logic [7:0]         pf_q, pf_d;
    logic [7:0]         pl_q, pl_d;
    logic               run, test, running, fire, dec, qual;
    logic               res_valid, res_lt;
    logic [NONCE_W-1:0] res_nonce;

    assign run     = control[CTL_RUN];
    assign test    = control[CTL_TEST];
    assign running = (state_q == S_RUN) || (state_q == S_DRAIN);

    sha3_target_cmp #(.TAG_W(NONCE_W), .REG_OUT(CMP_REG)) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (hash_out_valid),
        .digest_i (hash_out_digest),
        .target_i (difficulty),
        .tag_i    (hash_out_nonce),
        .valid_o  (res_valid),
        .lt_o     (res_lt),
        .tag_o    (res_nonce)
    );

    always_comb begin
        fire      = valid_q & hash_in_ready;
        // Late results arriving in IDLE/DONE must not underflow the in-flight count.
        dec       = hash_out_valid & running & (infl_q != '0);
        infl_d    = infl_q + IW'(fire) - IW'(dec);
        qual      = res_valid & (testing_q | res_lt);
        state_d   = state_q;
        cnt_d     = fire ? cnt_q + NONCE_W'(1) : cnt_q;
        valid_d   = 1'b0;
        sol_d     = sol_q;
        found_d   = found_q;
        testing_d = testing_q;
        hdr_d     = hdr_q;
        pf_d      = pf_q;
        pl_d      = pl_q;
        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d   = S_RUN;
                    cnt_d     = start_nonce;
                    valid_d   = 1'b1;
                    found_d   = 1'b0;
                    testing_d = test;
                    hdr_d     = header;
                    pf_d      = control[CTL_PAD_FIRST_LSB +: 8];
                    pl_d      = control[CTL_PAD_LAST_LSB +: 8];
                end
            end
            S_RUN: begin
                if (qual) begin
                    sol_d   = res_nonce;
                    found_d = 1'b1;
                end
                if (qual || !run)
                    state_d = S_DRAIN;
                else
                    valid_d = testing_q ? (valid_q & ~fire) : (infl_d != DEPTH);
            end
            S_DRAIN: begin
                if (infl_d == '0)
                    state_d = found_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                if (!run)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            infl_q    <= '0;
            valid_q   <= 1'b0;
            sol_q     <= '0;
            found_q   <= 1'b0;
            testing_q <= 1'b0;
            hdr_q     <= '0;
            pf_q      <= '0;
            pl_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            infl_q    <= infl_d;
            valid_q   <= valid_d;
            sol_q     <= sol_d;
            found_q   <= found_d;
            testing_q <= testing_d;
            hdr_q     <= hdr_d;
            pf_q      <= pf_d;
            pl_q      <= pl_d;
        end
    end

    assign hash_in_valid  = valid_q;
    assign hash_in_nonce  = cnt_q;
    assign hash_header    = hdr_q;
    assign hash_pad_first = pf_q;
    assign hash_pad_last  = pl_q;
    assign solution       = sol_q;
    assign irq            = found_q;
    always_comb begin
        status               = '0;
        status[STAT_FOUND]   = found_q;
        status[STAT_RUNNING] = running;
        status[STAT_TESTING] = testing_q;
    end
endmodule

// File: tb/tb_sha3_nonce_ctrl.sv
// tb_sha3_nonce_ctrl: in-order latency engine model plus first-qualifier scoreboard for sha3_nonce_ctrl.
module tb_sha3_nonce_ctrl;
    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] header, difficulty;
    logic [63:0]  start_nonce;
    logic [17:0]  control;
    logic         hash_in_valid, hash_in_ready;
    logic [63:0]  hash_in_nonce;
    logic [255:0] hash_header;
    logic [7:0]   hash_pad_first, hash_pad_last;
    logic         hash_out_valid;
    logic [255:0] hash_out_digest;
    logic [63:0]  hash_out_nonce;
    logic [63:0]  solution;
    logic [2:0]   status;
    logic         irq;

    always #5 clk = ~clk;

    sha3_nonce_ctrl dut (
        .clk(clk), .rst(rst), .header(header), .difficulty(difficulty),
        .start_nonce(start_nonce), .control(control),
        .hash_in_valid(hash_in_valid), .hash_in_ready(hash_in_ready), .hash_in_nonce(hash_in_nonce),
        .hash_header(hash_header), .hash_pad_first(hash_pad_first), .hash_pad_last(hash_pad_last),
        .hash_out_valid(hash_out_valid), .hash_out_digest(hash_out_digest), .hash_out_nonce(hash_out_nonce),
        .solution(solution), .status(status), .irq(irq)
    );

    typedef struct {
        logic [63:0]  start;
        logic [255:0] diff;
        logic [255:0] da;
        logic [255:0] db;
        bit           found;
        logic [63:0]  sol;
    } vec_t;
    vec_t tbl[6];

    int n_tests = 0, n_fail = 0;
    int cyc_n = 0, lat = 3, rdy_mode = 0, eng_mode = 1;
    logic [63:0] q_n[$];
    int          q_due[$];
    logic [63:0] fire_log[$];
    int n_issued, n_results, max_out, late_fires, irq_cyc, m_found_cyc;
    bit irq_seen, m_found, m_test, job_active, chk_order;
    logic [63:0]  exp_next, m_sol, t_start;
    logic [255:0] t_da, t_db, dig_const, m_diff;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] dig_for(input logic [63:0] n);
        if (eng_mode == 0) return (n == t_start) ? t_da : (n == t_start + 64'd1) ? t_db : '1;
        if (eng_mode == 1) return dig_const;
        return rnd256();
    endfunction

    // One clock: record the handshake/result seen at the edge, then drive next-cycle engine outputs.
    task automatic cyc();
        logic        f, rv;
        logic [63:0] fn, d;
        int          dd;
        f  = hash_in_valid & hash_in_ready;
        fn = hash_in_nonce;
        rv = hash_out_valid;
        @(posedge clk);
        #1;
        cyc_n++;
        if (rv) n_results++;
        if (f) begin
            if (chk_order) chk("issue_order", fn, exp_next);
            exp_next++;
            q_n.push_back(fn);
            q_due.push_back(cyc_n + lat);
            fire_log.push_back(fn);
            n_issued++;
            if (m_found && cyc_n > m_found_cyc + 1) late_fires++;
        end
        if (n_issued - n_results > max_out) max_out = n_issued - n_results;
        if (irq === 1'b1 && !irq_seen) begin
            irq_seen = 1;
            irq_cyc  = cyc_n;
        end
        hash_out_valid  = 1'b0;
        hash_out_digest = rnd256();
        hash_out_nonce  = {$urandom, $urandom};
        if (q_due.size() > 0 && q_due[0] <= cyc_n) begin
            d  = q_n.pop_front();
            dd = q_due.pop_front();
            hash_out_valid  = 1'b1;
            hash_out_nonce  = d;
            hash_out_digest = dig_for(d);
            if (job_active && !m_found && (m_test || hash_out_digest < m_diff)) begin
                m_found     = 1;
                m_sol       = d;
                m_found_cyc = cyc_n;
            end
        end
        hash_in_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom) :
                        (rdy_mode == 2) ? ~hash_in_ready : 1'b0;
    endtask

    task automatic start_job(input logic [63:0] s, input logic [255:0] dv, input bit tst);
        start_nonce = s;
        difficulty  = dv;
        m_diff      = dv;
        m_test      = tst;
        header      = rnd256();
        control     = {8'($urandom), 8'($urandom), tst, 1'b1};
        exp_next    = s;
        m_found     = 0;
        job_active  = 1;
        n_issued    = 0;
        n_results   = 0;
        max_out     = 0;
        irq_seen    = 0;
        late_fires  = 0;
        chk_order   = 1;
        fire_log.delete();
        cyc();
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!(status[0] && !status[1]) && i < budget) begin
            cyc();
            i++;
        end
        chk("done_reached", status[0] & ~status[1], 1'b1);
    endtask

    task automatic stop_job();
        int i = 0;
        control[0] = 1'b0;
        job_active = 0;
        do begin
            cyc();
            i++;
        end while (status[1] && i < 300);
        chk("stop_idle", status[1], 1'b0);
        cyc();
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] ones, msb, d5, dv;
        int viol, i;
        bit tst;
        ones = '1;
        msb  = {1'b1, 255'b0};
        d5   = {8'h00, {248{1'b1}}};
        tbl[0] = '{64'h10,  ones,      256'h0,    256'h0,    1'b1, 64'h10};
        tbl[1] = '{64'h5,   d5,        d5,        d5 - 1,    1'b1, 64'h6};
        tbl[2] = '{64'h100, 256'h0,    256'h0,    256'h0,    1'b0, 64'h0};
        tbl[3] = '{64'h20,  msb,       msb,       msb - 1,   1'b1, 64'h21};
        tbl[4] = '{64'h30,  ones - 1,  ones,      ones - 2,  1'b1, 64'h31};
        tbl[5] = '{64'h40,  msb,       msb - 1,   ones,      1'b1, 64'h40};

        rst = 1'b1; header = '0; difficulty = '0; start_nonce = '0; control = '0;
        hash_in_ready = 1'b0; hash_out_valid = 1'b0; hash_out_digest = '0; hash_out_nonce = '0;
        job_active = 0; chk_order = 0; m_found = 0; m_test = 0; m_diff = '0;
        n_issued = 0; n_results = 0; max_out = 0; late_fires = 0; irq_seen = 0;
        exp_next = '0; t_start = '0; t_da = '0; t_db = '0; dig_const = '0;
        repeat (3) cyc();
        chk("rst_valid", hash_in_valid, 1'b0);
        chk("rst_solution", solution, 64'h0);
        chk("rst_status", status, 3'b000);
        chk("rst_irq", irq, 1'b0);
        chk("rst_nonce", hash_in_nonce, 64'h0);
        rst = 1'b0;
        cyc();

        eng_mode = 0; lat = 3; rdy_mode = 0;
        for (int k = 0; k < 6; k++) begin
            t_start = tbl[k].start; t_da = tbl[k].da; t_db = tbl[k].db;
            start_job(tbl[k].start, tbl[k].diff, 1'b0);
            if (tbl[k].found) begin
                wait_done(200);
                chk("tbl_solution", solution, tbl[k].sol);
                chk("tbl_status_done", status, 3'b001);
            end else begin
                repeat (60) cyc();
                chk("tbl_status_running", status, 3'b010);
            end
            stop_job();
            chk("tbl_status_idle", status, {2'b00, tbl[k].found});
        end

        eng_mode = 1; dig_const = '0; lat = 30;
        start_job(64'h10, ones, 1'b0);
        chk("cap_header", hash_header, header);
        chk("cap_pad_first", hash_pad_first, control[17:10]);
        chk("cap_pad_last", hash_pad_last, control[9:2]);
        wait_done(300);
        chk("depth_solution", solution, 64'h10);
        chk("depth_irq_latency", irq_cyc - m_found_cyc, 1);
        chk("depth_max_inflight", max_out, 24);
        chk("depth_issued", n_issued, 24);
        chk("depth_results", n_results, 24);
        stop_job();

        dig_const = '1; lat = 2;
        start_job(64'hFFFF_FFFF_FFFF_FFFE, 256'h0, 1'b0);
        i = 0;
        while (fire_log.size() < 4 && i < 50) begin cyc(); i++; end
        chk("wrap_count", fire_log.size() >= 4, 1'b1);
        if (fire_log.size() >= 4) begin
            chk("wrap_n0", fire_log[0], 64'hFFFF_FFFF_FFFF_FFFE);
            chk("wrap_n1", fire_log[1], 64'hFFFF_FFFF_FFFF_FFFF);
            chk("wrap_n2", fire_log[2], 64'h0);
            chk("wrap_n3", fire_log[3], 64'h1);
        end
        chk("wrap_status", status, 3'b010);
        stop_job();
        chk("wrap_status_idle", status, 3'b000);

        start_job(64'h1234, 256'h0, 1'b1);
        repeat (40) cyc();
        chk("test_issues", n_issued, 1);
        chk("test_solution", solution, 64'h1234);
        chk("test_status", status, 3'b101);
        stop_job();

        lat = 5; rdy_mode = 2;
        start_job(64'h500, 256'h0, 1'b0);
        i = 0;
        while (n_issued < 10 && i < 100) begin cyc(); i++; end
        control[0] = 1'b0; hash_in_ready = 1'b0; rdy_mode = 3; job_active = 0;
        viol = 0; i = 0;
        while (status[1] && i < 200) begin
            cyc();
            if (status[1] != (n_issued != n_results)) viol++;
            i++;
        end
        chk("drop_issued", n_issued, 10);
        chk("drop_results", n_results, 10);
        chk("drop_running_track", viol, 0);
        chk("drop_status", status, 3'b000);
        cyc(); cyc();
        rdy_mode = 0;

        lat = 30; dig_const = '0;
        start_job(64'h900, ones, 1'b0);
        i = 0;
        while (n_issued - n_results < 12 && i < 50) begin cyc(); i++; end
        chk("rst_inflight", n_issued - n_results, 12);
        control[0] = 1'b0; job_active = 0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mid_rst_valid", hash_in_valid, 1'b0);
        chk("mid_rst_solution", solution, 64'h0);
        chk("mid_rst_status", status, 3'b000);
        chk("mid_rst_irq", irq, 1'b0);
        chk("mid_rst_header", hash_header, 256'h0);
        i = 0;
        while ((q_n.size() > 0 || hash_out_valid) && i < 100) begin cyc(); i++; end
        cyc();
        chk("late_ignored_status", status, 3'b000);
        chk("late_ignored_solution", solution, 64'h0);
        start_job(64'h40, 256'h0, 1'b0);
        i = 0;
        while (fire_log.size() == 0 && i < 10) begin cyc(); i++; end
        chk("restart_first", (fire_log.size() > 0) ? fire_log[0] : 64'hDEAD, 64'h40);
        stop_job();

        rdy_mode = 1; eng_mode = 2;
        for (int j = 0; j < 6; j++) begin
            lat = $urandom_range(1, 40);
            tst = ($urandom_range(0, 3) == 0);
            dv  = rnd256() >> 4;
            start_job({$urandom, $urandom}, dv, tst);
            wait_done(3000);
            chk("rnd_solution", solution, m_sol);
            chk("rnd_irq", irq, 1'b1);
            chk("rnd_irq_latency", irq_cyc - m_found_cyc, 1);
            chk("rnd_no_late_issue", late_fires, 0);
            chk("rnd_all_returned", n_issued - n_results, 0);
            chk("rnd_depth_bound", max_out <= 24, 1'b1);
            chk("rnd_status", status, {tst, 2'b01});
            stop_job();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
